mouse_packet_decoder: RTL

MOUSE_PACKET_DECODER -- requirements
Module: mouse_packet_decoder

---
 rtl/vga_pkg.sv | 16 +
 rtl/mouse_axis_update.sv | 36 +++
 rtl/mouse_packet_decoder.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared display definitions used by the mouse path.
//   H_ACTIVE / V_ACTIVE : visible screen area in pixels
//   mouse_state_t       : packet decoder FSM states
package vga_pkg;

  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 600;

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2,
    UPDATE  = 2'd3
  } mouse_state_t;

endpackage

// File: rtl/mouse_axis_update.sv
// One-axis cursor update: pos +/- delta, clamped to [0, MAX]. Purely
// combinational; the position register lives in the parent.
//   pos      : current position
//   delta    : 9-bit two's complement movement
//   subtract : 1 = pos - delta (screen Y grows downward), 0 = pos + delta
//   pos_next : clamped result
module mouse_axis_update #(
  parameter int MAX = 799
) (
  input  logic              [11:0] pos,
  input  logic signed       [8:0]  delta,
  input  logic                     subtract,
  output logic              [11:0] pos_next
);

  localparam logic signed [13:0] MAX_S = 14'(MAX);

  logic signed [13:0] pos_s;
  logic signed [13:0] delta_s;
  logic signed [13:0] sum;

  // 14 bits hold 4095 + 256 without wrapping, so the clamp sees the true sign.
  always_comb begin
    pos_s   = $signed({2'b00, pos});
    delta_s = $signed({{5{delta[8]}}, delta});
    sum     = subtract ? (pos_s - delta_s) : (pos_s + delta_s);
    if (sum < 14'sd0) begin
      pos_next = '0;
    end else if (sum > MAX_S) begin
      pos_next = 12'(MAX);
    end else begin
      pos_next = sum[11:0];
    end
  end

endmodule

// File: rtl/mouse_packet_decoder.sv
// Decodes 3-byte PS/2 mouse packets into a clamped cursor position and
// button levels.
//   clk, rst         : system clock, async active-low reset
//   rx_data/rx_valid : byte stream from the PS/2 receiver
//   mouse_xpos/ypos  : cursor position (Y grows downward)
//   left/right_mouse : button levels
//   packet_valid     : 1-cycle pulse when the outputs update
//   sync_err         : 1-cycle pulse when a byte or partial packet is dropped
//
// state   | meaning
// WAIT_B0 | idle, next byte must be a status byte (bit3 = 1)
// WAIT_B1 | status held, waiting for X byte
// WAIT_B2 | X held, waiting for Y byte
// UPDATE  | packet complete; outputs load on exit, new status may arrive
module mouse_packet_decoder
  import vga_pkg::*;
#(
  parameter int X_MAX          = H_ACTIVE - 1,
  parameter int Y_MAX          = V_ACTIVE - 1,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [11:0] mouse_xpos,
  output logic [11:0] mouse_ypos,
  output logic        left_mouse,
  output logic        right_mouse,
  output logic        packet_valid,
  output logic        sync_err
);

  localparam int              CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [11:0]      X_HOME   = 12'((X_MAX + 1) / 2);
  localparam logic [11:0]      Y_HOME   = 12'((Y_MAX + 1) / 2);

  mouse_state_t     state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  // Only the status bits that matter: {y_ovf, x_ovf, y_sign, x_sign, right, left}
  logic [5:0]       status;
  logic [7:0]       x_byte, y_byte;
  logic             load_status, load_x, load_y, drop, timeout;
  logic             sync_pend;
  logic signed [8:0] delta_x, delta_y;
  logic [11:0]      x_next, y_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= WAIT_B0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    load_status = 1'b0;
    load_x      = 1'b0;
    load_y      = 1'b0;
    drop        = 1'b0;
    timeout     = 1'b0;
    case (state)
      WAIT_B0, UPDATE: begin
        state_next = WAIT_B0;
        cnt_next   = '0;
        if (rx_valid) begin
          if (rx_data[3]) begin
            load_status = 1'b1;
            state_next  = WAIT_B1;
          end else begin
            drop = 1'b1;
          end
        end
      end
      WAIT_B1: begin
        if (rx_valid) begin
          load_x     = 1'b1;
          state_next = WAIT_B2;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          timeout    = 1'b1;
          state_next = WAIT_B0;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      WAIT_B2: begin
        if (rx_valid) begin
          load_y     = 1'b1;
          state_next = UPDATE;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          timeout    = 1'b1;
          state_next = WAIT_B0;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: state_next = WAIT_B0;
    endcase
  end

  assign delta_x = status[4] ? 9'sd0 : $signed({status[2], x_byte});
  assign delta_y = status[5] ? 9'sd0 : $signed({status[3], y_byte});

  mouse_axis_update #(.MAX(X_MAX)) u_axis_x (
    .pos      (mouse_xpos),
    .delta    (delta_x),
    .subtract (1'b0),
    .pos_next (x_next)
  );

  mouse_axis_update #(.MAX(Y_MAX)) u_axis_y (
    .pos      (mouse_ypos),
    .delta    (delta_y),
    .subtract (1'b1),
    .pos_next (y_next)
  );

  // A bad byte arriving during UPDATE would collide with packet_valid, so its
  // sync_err is deferred by one cycle through sync_pend.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status       <= '0;
      x_byte       <= '0;
      y_byte       <= '0;
      mouse_xpos   <= X_HOME;
      mouse_ypos   <= Y_HOME;
      left_mouse   <= 1'b0;
      right_mouse  <= 1'b0;
      packet_valid <= 1'b0;
      sync_err     <= 1'b0;
      sync_pend    <= 1'b0;
    end else begin
      if (load_status) status <= {rx_data[7:4], rx_data[1:0]};
      if (load_x)      x_byte <= rx_data;
      if (load_y)      y_byte <= rx_data;
      if (state == UPDATE) begin
        mouse_xpos  <= x_next;
        mouse_ypos  <= y_next;
        left_mouse  <= status[0];
        right_mouse <= status[1];
      end
      packet_valid <= (state == UPDATE);
      sync_err     <= (drop && (state != UPDATE)) || timeout || sync_pend;
      sync_pend    <= drop && (state == UPDATE);
    end
  end

endmodule
